axi_master_arbiter: RTL and testbench
=====================================

// Module: axi_master_arbiter
// PURPOSE
//  Shares the single AXI4 master port (io_master_*) between the IFU (read-only) and the LSU (read/write).
//  Each requester uses a simple valid/ready request plus a one-cycle response pulse.
//  Round-robin grant; one outstanding transaction total; single-beat transfers only (len=0, INCR).
//  Sits between the core front-end/LSU and the SoC AXI fabric.
// PARAMETERS
//  IFU_ID          4'd0   AXI ID driven for IFU transactions
//  LSU_ID          4'd1   AXI ID driven for LSU transactions
//  TIMEOUT_CYCLES  16'd255  watchdog limit in cycles (used only with AXI_ARB_TIMEOUT_EN)
// PORTS
//  clock               in   1   single clock
//  reset               in   1   asynchronous, active-low reset
//  ifu_req_valid       in   1   IFU fetch request
//  ifu_req_ready       out  1   IFU request accepted this cycle
//  ifu_addr            in   32  fetch address
//  ifu_rsp_valid       out  1   one-cycle pulse: fetch done
//  ifu_rdata           out  32  fetched word (valid with ifu_rsp_valid)
//  ifu_rsp_err         out  1   rresp!=0 or rid!=IFU_ID
//  lsu_req_valid       in   1   LSU request
//  lsu_req_ready       out  1   LSU request accepted this cycle
//  lsu_wen             in   1   1=write, 0=read
//  lsu_addr            in   32  access address
//  lsu_size            in   3   AXI size (0/1/2)
//  lsu_wdata, lsu_wstrb in  32,4  write data / byte strobes
//  lsu_rsp_valid       out  1   one-cycle pulse: access done (read data or B response)
//  lsu_rdata           out  32  load data (0 for writes)
//  lsu_rsp_err         out  1   rresp/bresp!=0 or ID mismatch
//  timeout_flag        out  1   sticky watchdog flag (tied 0 without the macro)
//  io_master_aw{valid,ready,addr,id,len,size,burst}  out/in/out...  1,1,32,4,8,3,2
//  io_master_w{valid,ready,data,strb,last}           1,1,32,4,1
//  io_master_b{ready,valid,resp,id}                  out,in,in,in  1,1,2,4
//  io_master_ar{valid,ready,addr,id,len,size,burst}  1,1,32,4,8,3,2
//  io_master_r{ready,valid,resp,data,last,id}        out,in...  1,1,2,32,1,4
// BEHAVIOUR
//  States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset: IDLE, last_grant=LSU, all outputs 0.
//  IDLE: grant = the only valid requester; if both are valid, grant the one not in last_grant.
//   *_req_ready = (state==IDLE) & grant (combinational). On acceptance, latch addr/size/wdata/wstrb/wen/owner
//   and update last_grant. IFU -> RD_ADDR, size 3'b010. LSU -> RD_ADDR if !lsu_wen, else WR_REQ.
//  RD_ADDR: arvalid=1; araddr/arsize/arid held stable until arready; then RD_DATA.
//  RD_DATA: rready=1; on rvalid, register rdata; err = (rresp!=0)|(rid!=owner ID); go to IDLE.
//   Owner rsp_valid is high in the following cycle (first IDLE cycle); a new grant may occur in that same cycle.
//  WR_REQ: awvalid and wvalid both raised on entry. Each drops independently after its own handshake
//   (aw_done/w_done flags). wlast=wvalid. Move to WR_RESP when both are done, including a same-cycle handshake.
//  WR_RESP: bready=1; on bvalid, err=(bresp!=0)|(bid!=LSU_ID); lsu_rsp_valid next cycle with lsu_rdata=0; go to IDLE.
//  Constants: awlen=arlen=0, burst=2'b01, awsize=lsu_size. bready=0 and rready=0 outside their states,
//   so stray beats are not consumed.
//  Minimum read latency: accept at T0, AR at T1, R at T2 (zero-wait slave), rsp_valid at T3. Write minimum is the same.
//  Reset mid-transaction: abandons the transaction immediately; all valids/rsp drop asynchronously; returns to IDLE.
//  rsp_valid never pulses without a prior acceptance; exactly one response per accepted request.
// CONFIGURATION
//  AXI_ARB_TIMEOUT_EN defined: a 16-bit counter runs in every non-IDLE state and clears on any AXI handshake.
//   When it reaches TIMEOUT_CYCLES: drop all valids/readies, pulse owner rsp_valid with err=1 and rdata=0,
//   set timeout_flag (sticky until reset), go to IDLE.
//  Not defined: counter absent, timeout_flag tied 0, the block waits indefinitely.
// TESTING
//  IFU read 0x8000_0000, arready=1, rvalid next cycle with rdata 0x0000_0413 -> araddr=0x80000000,
//   arid=0, arsize=2, ifu_rsp_valid for 1 cycle, ifu_rdata=0x413, err=0.
//  IFU and LSU both valid from reset, repeated 4 times -> grants IFU, LSU, IFU, LSU; never two outstanding.
//  LSU write 0xa000_03f8 data 0x41 strb 4'b0001, awready delayed 3 cycles, wready=1 ->
//   wvalid high 1 cycle, awvalid high 4 cycles, bresp=0 -> lsu_rsp_valid with err=0.
//  LSU read size 0 at 0x8000_0003, rresp=2'b10 -> arsize=0, lsu_rsp_err=1, lsu_rdata=rdata.
//  reset low during RD_DATA -> arvalid/rready/rsp outputs 0 immediately; after release, IDLE and the next IFU request is served.
//  Macro on, TIMEOUT_CYCLES=8, arready stuck 0 -> after 8 cycles arvalid drops, ifu_rsp_err=1, timeout_flag=1.

Source files
------------

// File: rtl/axi_master_arbiter_if.sv
// AXI4 master-port bundle between the IFU/LSU arbiter and the SoC fabric.
// The arbiter uses the master modport; a fabric model or slave uses the slave modport.
interface axi_master_arbiter_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rresp, rdata, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rresp, rdata, rlast, rid
  );
endinterface

// File: rtl/axi_master_arbiter.sv
// Round-robin IFU/LSU arbiter onto one AXI4 master port, one single-beat transaction in flight.
// Optional watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_master_arbiter #(
  parameter logic [3:0]  IFU_ID         = 4'd0,
  parameter logic [3:0]  LSU_ID         = 4'd1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,

  output logic        timeout_flag,

  axi_master_arbiter_if.master io_master
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, last_grant_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        grant_ifu, grant_lsu, accept_ifu, accept_lsu;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [3:0]  owner_id;
  logic        unused_rlast;

  // With both requesters valid, the one not served last time wins.
  assign grant_ifu  = ifu_req_valid & (~lsu_req_valid | (last_grant_q == OWN_LSU));
  assign grant_lsu  = lsu_req_valid & (~ifu_req_valid | (last_grant_q == OWN_IFU));
  assign accept_ifu = (state_q == IDLE) & grant_ifu;
  assign accept_lsu = (state_q == IDLE) & grant_lsu;

  assign ifu_req_ready = accept_ifu;
  assign lsu_req_ready = accept_lsu;

  assign owner_id = (owner_q == OWN_IFU) ? IFU_ID : LSU_ID;

  assign io_master.arvalid = (state_q == RD_ADDR);
  assign io_master.araddr  = addr_q;
  assign io_master.arid    = owner_id;
  assign io_master.arlen   = 8'd0;
  assign io_master.arsize  = size_q;
  assign io_master.arburst = 2'b01;
  assign io_master.rready  = (state_q == RD_DATA);

  assign io_master.awvalid = (state_q == WR_REQ) & ~aw_done_q;
  assign io_master.awaddr  = addr_q;
  assign io_master.awid    = LSU_ID;
  assign io_master.awlen   = 8'd0;
  assign io_master.awsize  = size_q;
  assign io_master.awburst = 2'b01;
  assign io_master.wvalid  = (state_q == WR_REQ) & ~w_done_q;
  assign io_master.wdata   = wdata_q;
  assign io_master.wstrb   = wstrb_q;
  assign io_master.wlast   = (state_q == WR_REQ) & ~w_done_q;
  assign io_master.bready  = (state_q == WR_RESP);

  assign ar_hs = io_master.arvalid & io_master.arready;
  assign r_hs  = io_master.rready  & io_master.rvalid;
  assign aw_hs = io_master.awvalid & io_master.awready;
  assign w_hs  = io_master.wvalid  & io_master.wready;
  assign b_hs  = io_master.bready  & io_master.bvalid;

  // Single-beat transfers only, so the last flag carries no information.
  assign unused_rlast = io_master.rlast;

  assign ifu_rsp_valid = rsp_valid_q & (owner_q == OWN_IFU);
  assign lsu_rsp_valid = rsp_valid_q & (owner_q == OWN_LSU);
  assign ifu_rsp_err   = ifu_rsp_valid & rsp_err_q;
  assign lsu_rsp_err   = lsu_rsp_valid & rsp_err_q;
  assign ifu_rdata     = rdata_q;
  assign lsu_rdata     = rdata_q;

`ifdef AXI_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        wd_flag_q, any_hs, timeout_hit;

  assign any_hs      = ar_hs | r_hs | aw_hs | w_hs | b_hs;
  // Fires on the cycle the count would reach the limit, so valids stay up exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state_q != IDLE) & ~any_hs & (wd_cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      wd_flag_q <= 1'b0;
    end else begin
      wd_cnt_q  <= ((state_q == IDLE) || any_hs) ? '0 : wd_cnt_q + 16'd1;
      wd_flag_q <= wd_flag_q | timeout_hit;
    end
  end

  assign timeout_flag = wd_flag_q;
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign timeout_flag   = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (accept_ifu)      state_d = RD_ADDR;
        else if (accept_lsu) state_d = lsu_wen ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          rdata_d     = io_master.rdata;
          rsp_err_d   = (io_master.rresp != 2'b00) | (io_master.rid != owner_id);
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; a same-cycle pair counts as both done.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          rdata_d     = '0;
          rsp_err_d   = (io_master.bresp != 2'b00) | (io_master.bid != LSU_ID);
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI_ARB_TIMEOUT_EN
    if (timeout_hit) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rdata_d     = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the request datapath is reset as well so the AXI address/data outputs read 0 out of reset.
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      if (accept_ifu) begin
        owner_q      <= OWN_IFU;
        last_grant_q <= OWN_IFU;
        addr_q       <= ifu_addr;
        size_q       <= 3'b010;
      end else if (accept_lsu) begin
        owner_q      <= OWN_LSU;
        last_grant_q <= OWN_LSU;
        addr_q       <= lsu_addr;
        size_q       <= lsu_size;
        wdata_q      <= lsu_wdata;
        wstrb_q      <= lsu_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: reads, writes, round-robin, errors, async reset, watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_axi_master_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_size;
  logic [3:0]  lsu_wstrb;
  logic        timeout_flag;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_ifu;
  logic [3:0]  exp_id;
  logic [31:0] exp_addr, exp_data;

  axi_master_arbiter_if bus ();

  axi_master_arbiter #(
    .IFU_ID         (4'd0),
    .LSU_ID         (4'd1),
    .TIMEOUT_CYCLES (16'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wdata     (lsu_wdata),
    .lsu_wstrb     (lsu_wstrb),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .timeout_flag  (timeout_flag),
    .io_master     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_size = '0; lsu_wdata = '0; lsu_wstrb = '0;
    bus.awready = 0; bus.wready = 0;
    bus.bvalid = 0; bus.bresp = '0; bus.bid = '0;
    bus.arready = 0;
    bus.rvalid = 0; bus.rresp = '0; bus.rdata = '0; bus.rlast = 1'b1; bus.rid = '0;

    // ---- reset state ----
    tick(); tick(); settle();
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_ifu_rsp", ifu_rsp_valid, 0);
    check("rst_lsu_rsp", lsu_rsp_valid, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    tick();
    reset = 1;

    // ---- IFU read 0x8000_0000, zero-wait slave ----
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; bus.arready = 1;
    settle();
    check("rd1_ifu_ready", ifu_req_ready, 1);
    check("rd1_lsu_ready", lsu_req_ready, 0);
    tick(); ifu_req_valid = 0; settle();
    check("rd1_arvalid", bus.arvalid, 1);
    check("rd1_araddr", bus.araddr, 32'h8000_0000);
    check("rd1_arid", bus.arid, 0);
    check("rd1_arsize", bus.arsize, 2);
    check("rd1_arlen", bus.arlen, 0);
    check("rd1_arburst", bus.arburst, 1);
    check("rd1_rready_in_ar", bus.rready, 0);
    tick(); bus.rvalid = 1; bus.rdata = 32'h0000_0413; bus.rresp = 0; bus.rid = 0; settle();
    check("rd1_rready", bus.rready, 1);
    check("rd1_arvalid_drop", bus.arvalid, 0);
    check("rd1_rsp_early", ifu_rsp_valid, 0);
    tick(); bus.rvalid = 0; settle();
    check("rd1_rsp_valid", ifu_rsp_valid, 1);
    check("rd1_rdata", ifu_rdata, 32'h0000_0413);
    check("rd1_err", ifu_rsp_err, 0);
    check("rd1_lsu_rsp", lsu_rsp_valid, 0);
    check("rd1_rready_idle", bus.rready, 0);
    tick(); settle();
    check("rd1_rsp_pulse_end", ifu_rsp_valid, 0);

    // ---- round-robin from reset: both valid for four grants ----
    reset = 0; #1; reset = 1;
    tick();
    lsu_wen = 0; lsu_size = 3'd2; lsu_addr = 32'h0000_1000; ifu_addr = 32'h8000_0100;
    bus.arready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_ifu  = (k % 2 == 0);
      exp_id   = exp_ifu ? 4'd0 : 4'd1;
      exp_addr = exp_ifu ? 32'h8000_0100 : 32'h0000_1000;
      exp_data = 32'hd000_0000 + k;
      ifu_req_valid = 1; lsu_req_valid = 1; settle();
      check("rr_ifu_ready", ifu_req_ready, exp_ifu);
      check("rr_lsu_ready", lsu_req_ready, !exp_ifu);
      tick(); settle();
      check("rr_arvalid", bus.arvalid, 1);
      check("rr_arid", bus.arid, exp_id);
      check("rr_araddr", bus.araddr, exp_addr);
      check("rr_busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
      tick(); bus.rvalid = 1; bus.rid = exp_id; bus.rdata = exp_data; bus.rresp = 0; settle();
      check("rr_rready", bus.rready, 1);
      check("rr_busy_ready2", {ifu_req_ready, lsu_req_ready}, 0);
      tick(); bus.rvalid = 0;
      if (k == 3) begin
        ifu_req_valid = 0; lsu_req_valid = 0;
      end
      settle();
      check("rr_ifu_rsp", ifu_rsp_valid, exp_ifu);
      check("rr_lsu_rsp", lsu_rsp_valid, !exp_ifu);
      check("rr_rdata", exp_ifu ? ifu_rdata : lsu_rdata, exp_data);
      check("rr_err", ifu_rsp_err | lsu_rsp_err, 0);
    end
    tick(); settle();
    check("rr_quiet_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check("rr_quiet_arvalid", bus.arvalid, 0);

    // ---- LSU write, awready delayed 3 cycles ----
    bus.arready = 0;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'ha000_03f8; lsu_size = 3'd0;
    lsu_wdata = 32'h0000_0041; lsu_wstrb = 4'b0001;
    bus.awready = 0; bus.wready = 1;
    settle();
    check("wr1_lsu_ready", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; settle();
    check("wr1_awvalid_c1", bus.awvalid, 1);
    check("wr1_wvalid_c1", bus.wvalid, 1);
    check("wr1_wlast", bus.wlast, 1);
    check("wr1_awaddr", bus.awaddr, 32'ha000_03f8);
    check("wr1_awid", bus.awid, 1);
    check("wr1_awsize", bus.awsize, 0);
    check("wr1_awlen", bus.awlen, 0);
    check("wr1_awburst", bus.awburst, 1);
    check("wr1_wdata", bus.wdata, 32'h0000_0041);
    check("wr1_wstrb", bus.wstrb, 4'b0001);
    tick(); settle();
    check("wr1_awvalid_c2", bus.awvalid, 1);
    check("wr1_wvalid_c2", bus.wvalid, 0);
    check("wr1_wlast_c2", bus.wlast, 0);
    tick(); settle();
    check("wr1_awvalid_c3", bus.awvalid, 1);
    tick(); bus.awready = 1; settle();
    check("wr1_awvalid_c4", bus.awvalid, 1);
    check("wr1_bready_early", bus.bready, 0);
    tick(); bus.awready = 0; bus.bvalid = 1; bus.bresp = 0; bus.bid = 4'd1; settle();
    check("wr1_awvalid_drop", bus.awvalid, 0);
    check("wr1_bready", bus.bready, 1);
    tick(); bus.bvalid = 0; settle();
    check("wr1_rsp_valid", lsu_rsp_valid, 1);
    check("wr1_err", lsu_rsp_err, 0);
    check("wr1_rdata", lsu_rdata, 0);
    check("wr1_bready_idle", bus.bready, 0);
    tick(); settle();
    check("wr1_rsp_pulse_end", lsu_rsp_valid, 0);

    // ---- LSU write with same-cycle AW/W handshake and bid mismatch ----
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h1000_0010; lsu_size = 3'd2;
    lsu_wdata = 32'hcafe_f00d; lsu_wstrb = 4'hf;
    bus.awready = 1; bus.wready = 1;
    settle();
    check("wr2_lsu_ready", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; settle();
    check("wr2_aw_w_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    check("wr2_wdata", bus.wdata, 32'hcafe_f00d);
    tick(); bus.bvalid = 1; bus.bresp = 0; bus.bid = 4'd0; settle();
    check("wr2_aw_w_drop", {bus.awvalid, bus.wvalid}, 2'b00);
    check("wr2_bready", bus.bready, 1);
    tick(); bus.bvalid = 0; bus.awready = 0; bus.wready = 0; settle();
    check("wr2_rsp_valid", lsu_rsp_valid, 1);
    check("wr2_err_bid", lsu_rsp_err, 1);
    tick();

    // ---- LSU byte read with SLVERR ----
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0003; lsu_size = 3'd0; bus.arready = 1;
    settle();
    check("rd2_lsu_ready", lsu_req_ready, 1);
    check("rd2_ifu_ready", ifu_req_ready, 0);
    tick(); lsu_req_valid = 0; settle();
    check("rd2_arsize", bus.arsize, 0);
    check("rd2_araddr", bus.araddr, 32'h8000_0003);
    check("rd2_arid", bus.arid, 1);
    tick(); bus.rvalid = 1; bus.rresp = 2'b10; bus.rid = 4'd1; bus.rdata = 32'hdead_beef; settle();
    check("rd2_rready", bus.rready, 1);
    tick(); bus.rvalid = 0; bus.rresp = 0; settle();
    check("rd2_rsp_valid", lsu_rsp_valid, 1);
    check("rd2_err", lsu_rsp_err, 1);
    check("rd2_rdata", lsu_rdata, 32'hdead_beef);
    check("rd2_ifu_rsp", ifu_rsp_valid, 0);
    tick();

    // ---- reset asserted while waiting in RD_DATA ----
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; bus.arready = 1; settle();
    check("rst_mid_ready", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; settle();
    check("rst_mid_arvalid", bus.arvalid, 1);
    tick(); settle();
    check("rst_mid_rready", bus.rready, 1);
    reset = 0; settle();
    check("rst_async_arvalid", bus.arvalid, 0);
    check("rst_async_rready", bus.rready, 0);
    check("rst_async_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    bus.rvalid = 1; bus.rdata = 32'h0000_1111; bus.rid = 0;
    tick(); settle();
    check("rst_hold_rready", bus.rready, 0);
    reset = 1;
    tick(); settle();
    check("rst_rel_rsp", ifu_rsp_valid, 0);
    check("rst_rel_stray_rready", bus.rready, 0);
    bus.rvalid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0044; settle();
    check("rst_rel_ready", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; settle();
    check("rst_rel_araddr", bus.araddr, 32'h8000_0044);
    tick(); bus.rvalid = 1; bus.rdata = 32'h00b0_0093; bus.rid = 0; bus.rresp = 0; settle();
    tick(); bus.rvalid = 0; settle();
    check("rst_rel_rsp_valid", ifu_rsp_valid, 1);
    check("rst_rel_rdata", ifu_rdata, 32'h00b0_0093);
    check("rst_rel_err", ifu_rsp_err, 0);
    tick();

`ifdef AXI_ARB_TIMEOUT_EN
    // ---- watchdog: arready stuck low, limit 8 ----
    bus.arready = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080; settle();
    check("to_ready", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("to_arvalid_hold", bus.arvalid, 1);
      tick();
    end
    settle();
    check("to_arvalid_drop", bus.arvalid, 0);
    check("to_rsp_valid", ifu_rsp_valid, 1);
    check("to_err", ifu_rsp_err, 1);
    check("to_rdata", ifu_rdata, 0);
    check("to_flag", timeout_flag, 1);
    tick(); settle();
    check("to_rsp_pulse_end", ifu_rsp_valid, 0);
    check("to_flag_sticky", timeout_flag, 1);
`else
    check("no_wd_flag", timeout_flag, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
